// File: rtl/axis_frame_csum.sv
// AXI-Stream pass-through that appends a modular-sum checksum word (with tlast) to each frame.
// Counts completed frames and flags frames force-ended at MAX_LEN words.
module axis_frame_csum #(
    parameter int unsigned DW      = 16,
    parameter int unsigned MAX_LEN = 2048,
    parameter int unsigned LW      = 12,
    parameter int unsigned CW      = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [DW-1:0] s_tdata_i,
    input  logic          s_tvalid_i,
    input  logic          s_tlast_i,
    output logic          s_tready_o,
    output logic [DW-1:0] m_tdata_o,
    output logic          m_tvalid_o,
    output logic          m_tlast_o,
    input  logic          m_tready_i,
    output logic [CW-1:0] frame_cnt_o,
    output logic          err_oversize_o
);

    localparam logic [0:0] StPass = 1'b0;
    localparam logic [0:0] StCsum = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [DW-1:0] sum_q, sum_d;
    logic [LW-1:0] len_q, len_d;
    logic [DW-1:0] m_tdata_q, m_tdata_d;
    logic          m_tvalid_q, m_tvalid_d;
    logic          m_tlast_q, m_tlast_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic          err_q, err_d;

    logic free;
    logic accept;
    logic at_max;

    assign free       = !m_tvalid_q || m_tready_i;
    // Gated by reset so no word is taken while the block is held in reset.
    assign s_tready_o = rst_ni && (state_q == StPass) && free;
    assign accept     = s_tvalid_i && s_tready_o;
    assign at_max     = (len_q == LW'(MAX_LEN - 1));

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        len_d       = len_q;
        m_tdata_d   = m_tdata_q;
        m_tvalid_d  = m_tvalid_q;
        m_tlast_d   = m_tlast_q;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;

        if (m_tvalid_q && m_tready_i) begin
            m_tvalid_d = 1'b0;
            if (m_tlast_q) begin
                frame_cnt_d = frame_cnt_q + CW'(1);
            end
        end

        case (state_q)
            StPass: begin
                if (accept) begin
                    m_tdata_d  = s_tdata_i;
                    m_tlast_d  = 1'b0;
                    m_tvalid_d = 1'b1;
                    sum_d      = sum_q + s_tdata_i;
                    len_d      = len_q + LW'(1);
                    if (s_tlast_i || at_max) begin
                        state_d = StCsum;
                    end
                    err_d = at_max && !s_tlast_i;
                end
            end
            default: begin
                if (free) begin
                    m_tdata_d  = sum_q;
                    m_tlast_d  = 1'b1;
                    m_tvalid_d = 1'b1;
                    sum_d      = '0;
                    len_d      = '0;
                    state_d    = StPass;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StPass;
            sum_q       <= '0;
            len_q       <= '0;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            len_q       <= len_d;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    assign m_tdata_o      = m_tdata_q;
    assign m_tvalid_o     = m_tvalid_q;
    assign m_tlast_o      = m_tlast_q;
    assign frame_cnt_o    = frame_cnt_q;
    assign err_oversize_o = err_q;

endmodule
